// File: rtl/br_resolve_queue.sv
// In-order branch resolution queue: fetch allocates, the branch bus resolves out of order,
// entries retire in program order. Define BRQ_LOCAL_CHECK_EN to add a local pred_pc comparison.
module br_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc_valid,
  input  logic [31:0]                alloc_pc,
  input  logic [31:0]                alloc_pred_pc,
  input  logic [TAG_W-1:0]           alloc_tag,
  input  logic                       alloc_is_jump,
  output logic                       alloc_ready,
  input  logic                       res_valid,
  input  logic [TAG_W-1:0]           res_tag,
  input  logic                       res_taken,
  input  logic [31:0]                res_target,
  output logic                       check,
  output logic [31:0]                pc_curr_update,
  output logic [31:0]                pc_out_br_bus,
  output logic                       was_taken_not_taken,
  output logic                       was_jump,
  input  logic                       mispredicted,
  output logic                       flush,
  output logic [31:0]                flush_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0]      pc;
    logic [TAG_W-1:0] tag;
    logic             is_jump;
    logic             taken;
    logic [31:0]      target;
  } entry_t;

  entry_t           entries_q [DEPTH];
  entry_t           entries_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] resolved_q, resolved_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             flush_q, flush_d;
  logic [31:0]      flush_pc_q, flush_pc_d;

`ifdef BRQ_LOCAL_CHECK_EN
  logic [31:0] pred_pc_q [DEPTH];
  logic [31:0] pred_pc_d [DEPTH];
`else
  logic unused_pred_pc;
  assign unused_pred_pc = ^alloc_pred_pc;
`endif

  entry_t      head;
  logic        head_valid;
  logic        check_int;
  logic        mp;
  logic        alloc_accept;
  logic [31:0] actual_next;

  // Retire side: everything here is a function of registered state plus rst/mispredicted.
  always_comb begin
    head         = entries_q[head_q];
    head_valid   = rst & valid_q[head_q];
    check_int    = head_valid & resolved_q[head_q] & ~flush_q;
    actual_next  = head.taken ? head.target : head.pc + 32'd4;
`ifdef BRQ_LOCAL_CHECK_EN
    mp           = check_int & (mispredicted | (actual_next != pred_pc_q[head_q]));
`else
    mp           = check_int & mispredicted;
`endif
    alloc_ready  = rst & (count_q != CNT_W'(DEPTH)) & ~flush_q;
    alloc_accept = alloc_valid & alloc_ready;

    check               = check_int;
    pc_curr_update      = head_valid ? head.pc     : 32'd0;
    pc_out_br_bus       = head_valid ? head.target : 32'd0;
    was_taken_not_taken = head_valid & head.taken;
    was_jump            = head_valid & head.is_jump;
    flush               = flush_q;
    flush_pc            = flush_pc_q;
    count               = count_q;
  end

  // NOTE: every variable gets its default before any conditional update, so no latch is inferred.
  always_comb begin
    valid_d    = valid_q;
    resolved_d = resolved_q;
    entries_d  = entries_q;
    head_d     = head_q;
    tail_d     = tail_q;
    flush_d    = 1'b0;
    flush_pc_d = flush_pc_q;
`ifdef BRQ_LOCAL_CHECK_EN
    pred_pc_d  = pred_pc_q;
`endif

    // Match against start-of-cycle state so a same-cycle allocation cannot be resolved.
    for (int i = 0; i < DEPTH; i++) begin
      if (res_valid && valid_q[i] && !resolved_q[i] && entries_q[i].tag == res_tag) begin
        resolved_d[i]       = 1'b1;
        entries_d[i].taken  = res_taken;
        entries_d[i].target = res_target;
      end
    end

    if (alloc_accept) begin
      valid_d[tail_q]    = 1'b1;
      resolved_d[tail_q] = 1'b0;
      entries_d[tail_q]  = '{pc: alloc_pc, tag: alloc_tag, is_jump: alloc_is_jump,
                             taken: 1'b0, target: 32'd0};
`ifdef BRQ_LOCAL_CHECK_EN
      pred_pc_d[tail_q]  = alloc_pred_pc;
`endif
      tail_d             = tail_q + PTR_W'(1);
    end

    if (check_int) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end

    count_d = count_q + CNT_W'(alloc_accept) - CNT_W'(check_int);

    // A mispredict squashes everything younger, including this cycle's alloc and resolve.
    if (mp) begin
      valid_d    = '0;
      resolved_d = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      flush_d    = 1'b1;
      flush_pc_d = actual_next;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q    <= '0;
      resolved_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= 32'd0;
    end else begin
      valid_q    <= valid_d;
      resolved_q <= resolved_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  // NOTE: payload storage has no reset; valid_q gates every use, so stale contents are harmless.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
`ifdef BRQ_LOCAL_CHECK_EN
    pred_pc_q <= pred_pc_d;
`endif
  end

endmodule

// File: tb/tb_br_resolve_queue.sv
// Self-checking bench for br_resolve_queue: directed scenarios plus a short random phase,
// checked against an in-order scoreboard of allocated entries.
module tb_br_resolve_queue;
  localparam int DEPTH = 8;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             alloc_valid;
  logic [31:0]      alloc_pc;
  logic [31:0]      alloc_pred_pc;
  logic [TAG_W-1:0] alloc_tag;
  logic             alloc_is_jump;
  logic             alloc_ready;
  logic             res_valid;
  logic [TAG_W-1:0] res_tag;
  logic             res_taken;
  logic [31:0]      res_target;
  logic             chk;
  logic [31:0]      pc_curr_update;
  logic [31:0]      pc_out_br_bus;
  logic             was_taken_not_taken;
  logic             was_jump;
  logic             mispredicted;
  logic             flush;
  logic [31:0]      flush_pc;
  logic [3:0]       count;

  br_resolve_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_pred_pc(alloc_pred_pc),
    .alloc_tag(alloc_tag), .alloc_is_jump(alloc_is_jump), .alloc_ready(alloc_ready),
    .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken), .res_target(res_target),
    .check(chk), .pc_curr_update(pc_curr_update), .pc_out_br_bus(pc_out_br_bus),
    .was_taken_not_taken(was_taken_not_taken), .was_jump(was_jump),
    .mispredicted(mispredicted), .flush(flush), .flush_pc(flush_pc), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      pc;
    logic [31:0]      pred_pc;
    logic [TAG_W-1:0] tag;
    logic             is_jump;
    logic             resolved;
    logic             taken;
    logic [31:0]      target;
  } mentry_t;

  mentry_t     exp_q[$];
  bit          m_flush = 1'b0;
  logic [31:0] m_flush_pc = 32'd0;
  logic [31:0] dut_ret_pc[$];
  int          n_dut_checks = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          base;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    alloc_valid = 1'b0; alloc_pc = 32'd0; alloc_pred_pc = 32'd0; alloc_tag = '0;
    alloc_is_jump = 1'b0; res_valid = 1'b0; res_tag = '0; res_taken = 1'b0;
    res_target = 32'd0; mispredicted = 1'b0;
  endtask

  // One clock: compare combinational outputs with current inputs, update the model, then
  // compare registered outputs just after the edge.
  task automatic tick();
    bit          e_check, e_mp, ready, was_rst;
    logic [31:0] act;
    mentry_t     h;
    #1;
    was_rst = !rst;
    e_check = rst && exp_q.size() > 0 && exp_q[0].resolved && !m_flush;
    ready   = rst && exp_q.size() != DEPTH && !m_flush;
    check("check_strobe", chk, e_check);
    check("alloc_ready", alloc_ready, ready);
    if (rst && exp_q.size() > 0) begin
      h = exp_q[0];
      check("head_pc", pc_curr_update, h.pc);
      check("head_jump", was_jump, h.is_jump);
      if (h.resolved) begin
        check("head_taken", was_taken_not_taken, h.taken);
        check("head_target", pc_out_br_bus, h.target);
      end
    end else begin
      check("idle_pc", pc_curr_update, 32'd0);
      check("idle_target", pc_out_br_bus, 32'd0);
      check("idle_taken", was_taken_not_taken, 1'b0);
      check("idle_jump", was_jump, 1'b0);
    end
    if (chk === 1'b1) begin
      n_dut_checks++;
      dut_ret_pc.push_back(pc_curr_update);
    end

    e_mp = 1'b0;
    act  = 32'd0;
    if (e_check) begin
      h    = exp_q[0];
      act  = h.taken ? h.target : h.pc + 32'd4;
      e_mp = mispredicted;
`ifdef BRQ_LOCAL_CHECK_EN
      if (act != h.pred_pc) e_mp = 1'b1;
`endif
    end

    if (!rst) begin
      exp_q.delete();
      m_flush    = 1'b0;
      m_flush_pc = 32'd0;
    end else if (e_mp) begin
      exp_q.delete();
      m_flush    = 1'b1;
      m_flush_pc = act;
    end else begin
      m_flush = 1'b0;
      if (res_valid) begin
        foreach (exp_q[i]) begin
          if (!exp_q[i].resolved && exp_q[i].tag == res_tag) begin
            exp_q[i].resolved = 1'b1;
            exp_q[i].taken    = res_taken;
            exp_q[i].target   = res_target;
          end
        end
      end
      if (e_check) void'(exp_q.pop_front());
      if (alloc_valid && ready)
        exp_q.push_back('{pc: alloc_pc, pred_pc: alloc_pred_pc, tag: alloc_tag,
                          is_jump: alloc_is_jump, resolved: 1'b0, taken: 1'b0, target: 32'd0});
    end

    @(posedge clk);
    #1;
    check("count", count, exp_q.size());
    check("flush", flush, m_flush);
    if (m_flush || was_rst) check("flush_pc", flush_pc, m_flush_pc);
  endtask

  task automatic alloc(input logic [31:0] pc, input logic [31:0] pred, input int tag,
                       input logic jump);
    clear_inputs();
    alloc_valid = 1'b1; alloc_pc = pc; alloc_pred_pc = pred;
    alloc_tag = TAG_W'(tag); alloc_is_jump = jump;
    tick();
    clear_inputs();
  endtask

  task automatic resolve(input int tag, input logic taken, input logic [31:0] target);
    clear_inputs();
    res_valid = 1'b1; res_tag = TAG_W'(tag); res_taken = taken; res_target = target;
    tick();
    clear_inputs();
  endtask

  task automatic idle(input int n);
    clear_inputs();
    repeat (n) tick();
  endtask

  function automatic bit tag_in_flight(input logic [TAG_W-1:0] t);
    foreach (exp_q[i]) if (exp_q[i].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    rst = 1'b0;
    clear_inputs();
    tick();
    tick();
    check("reset_count", count, 32'd0);
    rst = 1'b1;
    tick();

    // Single branch, resolved not-taken, correctly predicted.
    base = n_dut_checks;
    alloc(32'h100, 32'h104, 3, 1'b0);
    resolve(3, 1'b0, 32'h0);
    check("s1_check_high", chk, 1'b1);
    check("s1_pc", pc_curr_update, 32'h100);
    check("s1_dir", was_taken_not_taken, 1'b0);
    idle(2);
    check("s1_pulses", n_dut_checks - base, 32'd1);
    check("s1_no_flush", flush, 1'b0);

    // Out-of-order resolution retires in program order.
    dut_ret_pc.delete();
    alloc(32'h110, 32'h114, 1, 1'b0);
    alloc(32'h120, 32'h124, 2, 1'b0);
    alloc(32'h130, 32'h134, 3, 1'b0);
    resolve(3, 1'b0, 32'h0);
    check("s2_no_early_retire", chk, 1'b0);
    resolve(1, 1'b0, 32'h0);
    resolve(2, 1'b0, 32'h0);
    idle(3);
    check("s2_retired", dut_ret_pc.size(), 32'd3);
    if (dut_ret_pc.size() == 3) begin
      check("s2_order0", dut_ret_pc[0], 32'h110);
      check("s2_order1", dut_ret_pc[1], 32'h120);
      check("s2_order2", dut_ret_pc[2], 32'h130);
    end

    // Same-cycle alloc and resolve of one tag never matches.
    clear_inputs();
    alloc_valid = 1'b1; alloc_pc = 32'h140; alloc_pred_pc = 32'h900; alloc_tag = 4'd5;
    alloc_is_jump = 1'b1; res_valid = 1'b1; res_tag = 4'd5; res_taken = 1'b1;
    res_target = 32'h900;
    tick();
    idle(1);
    check("s2b_unresolved", chk, 1'b0);
    resolve(5, 1'b1, 32'h900);
    check("s2b_jump", was_jump, 1'b1);
    idle(2);

    // Mispredict with simultaneous alloc and younger resolution.
    alloc(32'h200, 32'h204, 6, 1'b0);
    alloc(32'h210, 32'h214, 7, 1'b0);
    resolve(6, 1'b1, 32'h400);
    clear_inputs();
    mispredicted = 1'b1;
    alloc_valid = 1'b1; alloc_pc = 32'h220; alloc_pred_pc = 32'h224; alloc_tag = 4'd8;
    res_valid = 1'b1; res_tag = 4'd7; res_taken = 1'b1; res_target = 32'h700;
    tick();
    check("s3_flush", flush, 1'b1);
    check("s3_flush_pc", flush_pc, 32'h400);
    check("s3_count", count, 32'd0);
    check("s3_check_in_flush", chk, 1'b0);
    alloc(32'h230, 32'h234, 9, 1'b0);
    check("s3_flush_alloc_dropped", count, 32'd0);
    idle(1);

    // Fill, drop on full, no pop-through.
    for (int i = 0; i < DEPTH; i++) alloc(32'h1000 + 32'(i * 16), 32'h1004 + 32'(i * 16), i, 1'b0);
    check("s4_full_ready", alloc_ready, 1'b0);
    alloc(32'h1800, 32'h1804, 8, 1'b0);
    check("s4_full_count", count, 32'd8);
    resolve(0, 1'b0, 32'h0);
    clear_inputs();
    alloc_valid = 1'b1; alloc_pc = 32'h2000; alloc_pred_pc = 32'h2004; alloc_tag = 4'd9;
    tick();
    clear_inputs();
    check("s4_after_pop_count", count, 32'd7);
    check("s4_after_pop_ready", alloc_ready, 1'b1);
    for (int t = DEPTH - 1; t >= 1; t--) resolve(t, 1'b0, 32'h0);
    idle(10);
    check("s4_drained", count, 32'd0);

    // Not-taken fall-through that disagrees with pred_pc.
    alloc(32'h300, 32'h500, 10, 1'b0);
    resolve(10, 1'b0, 32'h0);
    idle(1);
`ifdef BRQ_LOCAL_CHECK_EN
    check("s5_local_flush", flush, 1'b1);
    check("s5_local_flush_pc", flush_pc, 32'h304);
`else
    check("s5_no_flush", flush, 1'b0);
`endif
    idle(2);

    // Reset with four resolved entries in flight.
    for (int t = 1; t <= 4; t++) alloc(32'h600 + 32'(t * 4), 32'h604 + 32'(t * 4), t, 1'b0);
    for (int t = 4; t >= 1; t--) resolve(t, 1'b0, 32'h0);
    base = n_dut_checks;
    rst = 1'b0;
    tick();
    check("s6_count", count, 32'd0);
    check("s6_check", chk, 1'b0);
    check("s6_flush", flush, 1'b0);
    rst = 1'b1;
    idle(3);
    check("s6_no_retire", n_dut_checks - base, 32'd0);

    // Random mixed traffic.
    for (int c = 0; c < 400; c++) begin
      logic [TAG_W-1:0] t;
      int               idx;
      clear_inputs();
      if ($urandom_range(1, 0) == 1) begin
        t = TAG_W'($urandom_range(15, 0));
        while (tag_in_flight(t)) t = t + 1'b1;
        alloc_valid   = 1'b1;
        alloc_pc      = 32'h4000 + 32'(c * 4);
        alloc_pred_pc = ($urandom_range(1, 0) == 1) ? alloc_pc + 32'd4 : 32'h8000;
        alloc_tag     = t;
        alloc_is_jump = 1'($urandom_range(1, 0));
      end
      if (exp_q.size() > 0 && $urandom_range(1, 0) == 1) begin
        idx = $urandom_range(exp_q.size() - 1, 0);
        if (!exp_q[idx].resolved) begin
          res_valid  = 1'b1;
          res_tag    = exp_q[idx].tag;
          res_taken  = 1'($urandom_range(1, 0));
          res_target = ($urandom_range(1, 0) == 1) ? 32'h8000 : 32'h8100;
        end
      end
      mispredicted = ($urandom_range(7, 0) == 0);
      tick();
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/br_resolve_queue.md
# br_resolve_queue

In-order tracking queue for in-flight branch and jump predictions, placed between fetch and the branch predictor. Fetch allocates one entry per predicted control-flow instruction, tagged with its ROB tag. The branch unit resolves entries out of order over the branch bus. The queue retires resolved entries strictly in program order, drives the predictor's check/update port for each one, and raises a one-cycle flush with the corrected fetch PC on a misprediction.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, ≥2
- TAG_W, 4, ROB tag width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- alloc_valid  in  1  fetch allocates an entry this cycle
- alloc_pc  in  32  PC of the branch/jump
- alloc_pred_pc  in  32  next PC predicted at fetch
- alloc_tag  in  TAG_W  ROB tag of the instruction
- alloc_is_jump  in  1  unconditional jump
- alloc_ready  out  1  queue can accept an allocation
- res_valid  in  1  branch bus resolution valid
- res_tag  in  TAG_W  tag being resolved
- res_taken  in  1  actual direction
- res_target  in  32  actual taken target
- check  out  1  predictor check strobe (one cycle per retired entry)
- pc_curr_update  out  32  head entry PC
- pc_out_br_bus  out  32  head entry resolved target
- was_taken_not_taken  out  1  head entry actual direction
- was_jump  out  1  head entry jump flag
- mispredicted  in  1  predictor verdict, combinational in the same cycle as check
- flush  out  1  registered misprediction flush
- flush_pc  out  32  corrected fetch PC, valid while flush=1
- count  out  $clog2(DEPTH+1)  number of occupied entries

## Operation
- Entry fields: valid, resolved, pc, pred_pc, tag, is_jump, taken, target.
- Pointers: head and tail, each log2(DEPTH) bits, wrap modulo DEPTH. count is tracked separately.
- Full and empty are derived from count.

Allocation:
- alloc_ready = rst & (count != DEPTH) & ~flush.
- On alloc_valid & alloc_ready, write the tail entry: valid=1, resolved=0. Tail then increments.
- alloc_valid while alloc_ready=0 is dropped silently.

Resolution:
- On res_valid, the queue CAM-matches res_tag against entries with valid=1 and resolved=0.
- On a match: set resolved=1, taken=res_taken, target=res_target.
- Matching is done against state at the start of the cycle. An entry allocated in the same cycle never matches.
- No match: ignore. Multiple matches cannot occur; tags are unique in flight.

Retire:
- check = head valid & head resolved & ~flush. Asserted combinationally from registered state.
- The check outputs reflect the head entry whenever head is valid, and are 0 otherwise.
- When check=1, the head pops at the clock edge.
- actual_next = taken ? target : pc+4, computed with 32-bit wrap.

Mispredict (mp):
- mp = check & mispredicted.
- On mp, at the same edge:
  - all entries are invalidated; head=tail=0; count=0
  - any allocation and any resolution in that cycle are discarded
  - flush←1, flush_pc←actual_next of the head entry
- flush is a one-cycle pulse. check is forced 0 during the flush cycle.

## Timing
- Reset (rst=0 at an edge): all entries invalid, head=tail=0, count=0, flush=0, flush_pc=0. While rst=0: check=0, all check outputs 0, alloc_ready=0.
- Reset mid-operation discards every entry. No check or flush is issued for them.
- Latency:
  - An entry allocated at edge N can resolve in cycle N+1 at the earliest, and check in cycle N+2 at the earliest.
  - The resolution edge to check is 1 cycle minimum.
  - check to flush is 1 cycle.
- Throughput: one allocation, one resolution and one retirement per cycle.
- Count update: count_next = count + alloc_accept − pop.
- Full: when count=DEPTH, alloc_ready=0 even if the head retires in the same cycle. There is no pop-through.
- Empty: check=0. A resolution with no match is ignored.

## Configuration
- BRQ_LOCAL_CHECK_EN defined: the queue also compares locally. mp = check & (mispredicted | (actual_next != pred_pc)). This catches not-taken fall-through errors and stale-target cases the predictor does not flag.
- Not defined: mp = check & mispredicted only; the pred_pc storage is unused.

## Test plan
- Reset, then allocate pc=0x100 / pred_pc=0x104 / tag=3, then resolve tag 3 not-taken with mispredicted=0 → check=1 one cycle with pc_curr_update=0x100 and was_taken_not_taken=0; count returns 0; flush stays 0.
- Allocate tags 1, 2, 3; resolve in order 3, 1, 2 → check pulses in program order for tags 1, 2, 3; tag 3 does not retire before tag 1.
- Head pc=0x200 resolved taken with target 0x400, mispredicted=1 → next cycle flush=1, flush_pc=0x400, count=0; a simultaneous allocation and a resolution for a younger tag are both discarded.
- Fill to DEPTH=8 → alloc_ready=0; a 9th alloc_valid is dropped; head retirement at count=8 with alloc_valid=1 gives count=7, then alloc_ready=1.
- With BRQ_LOCAL_CHECK_EN: pc=0x300, pred_pc=0x500, resolved not-taken, mispredicted=0 → flush=1, flush_pc=0x304. Without the macro, the same stimulus gives no flush.
- rst=0 asserted with 4 entries resolved → next cycle count=0, check=0, flush=0; no check issued after rst returns to 1.
